// File: rtl/pipe_share_sched.sv
// Round-robin scheduler sharing one fixed-latency arithmetic pipeline among N_REQ requesters.
// Results return tagged with the requester ID that issued them.
module pipe_share_sched #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned W        = 10,
    parameter int unsigned PIPE_LAT = 3,
    localparam int unsigned ID_W    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    input  logic [N_REQ*W-1:0]   req_c,
    input  logic [N_REQ*W-1:0]   req_d,
    output logic [N_REQ-1:0]     req_ready,
    output logic [W-1:0]         pipe_a,
    output logic [W-1:0]         pipe_b,
    output logic [W-1:0]         pipe_c,
    output logic [W-1:0]         pipe_d,
    input  logic [W-1:0]         pipe_f,
    output logic                 res_valid,
    output logic [ID_W-1:0]      res_id,
    output logic [W-1:0]         res_data,
    output logic                 busy,
    output logic                 idle
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [ID_W-1:0] rr;
    logic [ID_W-1:0] win;
    logic            grant_any;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [W-1:0]    c_sel;
    logic [W-1:0]    d_sel;

    // Entry 0 is loaded alongside pipe_a..d, so entry PIPE_LAT lines up with pipe_f.
    logic [PIPE_LAT:0] tag_v;
    logic [ID_W-1:0]   tag_id [PIPE_LAT+1];

    assign busy = |tag_v;
    assign idle = (state == IDLE);

    // Two passes: indices at/after the pointer first, then the wrapped-around ones.
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        win       = '0;
        if (state == RUN && en) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!grant_any && req_valid[i] && ID_W'(i) >= rr) begin
                    grant_any    = 1'b1;
                    win          = ID_W'(i);
                    req_ready[i] = 1'b1;
                end
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!grant_any && req_valid[i] && ID_W'(i) < rr) begin
                    grant_any    = 1'b1;
                    win          = ID_W'(i);
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        c_sel = '0;
        d_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
                c_sel = req_c[i*W +: W];
                d_sel = req_d[i*W +: W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = busy ? DRAIN : IDLE;
            DRAIN: begin
                if (en)         state_nxt = RUN;
                else if (!busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= '0;
            tag_v     <= '0;
            pipe_a    <= '0;
            pipe_b    <= '0;
            pipe_c    <= '0;
            pipe_d    <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            for (int unsigned i = 0; i <= PIPE_LAT; i++) tag_id[i] <= '0;
        end else begin
            state <= state_nxt;
            if (grant_any) rr <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            pipe_a    <= a_sel;
            pipe_b    <= b_sel;
            pipe_c    <= c_sel;
            pipe_d    <= d_sel;
            tag_v     <= {tag_v[PIPE_LAT-1:0], grant_any};
            tag_id[0] <= win;
            for (int unsigned i = 1; i <= PIPE_LAT; i++) tag_id[i] <= tag_id[i-1];
            res_valid <= tag_v[PIPE_LAT];
            res_id    <= tag_id[PIPE_LAT];
            res_data  <= pipe_f;
        end
    end

endmodule

// File: tb/tb_pipe_share_sched.sv
// Bench for pipe_share_sched: models the external 3-stage pipeline and scoreboards tagged results.
module tb_pipe_share_sched;

    localparam int N  = 4;
    localparam int W  = 10;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en  = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a, req_b, req_c, req_d;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   pipe_a, pipe_b, pipe_c, pipe_d, pipe_f;
    logic           res_valid;
    logic [IW-1:0]  res_id;
    logic [W-1:0]   res_data;
    logic           busy, idle;

    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    logic [W-1:0] opc [N];
    logic [W-1:0] opd [N];

    exp_t sbq [$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_share_sched #(.N_REQ(N), .W(W), .PIPE_LAT(3)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .req_ready(req_ready),
        .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_d(pipe_d),
        .pipe_f(pipe_f),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .busy(busy), .idle(idle)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
            req_c[i*W +: W] = opc[i];
            req_d[i*W +: W] = opd[i];
        end
    end

    // External pipeline: no reset, three register stages.
    logic [W-1:0] p1s = '0, p1t = '0, p1d = '0, p2s = '0, p2d = '0, pf = '0;
    always @(posedge clk) begin
        p1s <= pipe_a + pipe_b;
        p1t <= pipe_c - pipe_d;
        p1d <= pipe_d;
        p2s <= p1s + p1t;
        p2d <= p1d;
        pf  <= p2s * p2d;
    end
    assign pipe_f = pf;

    function automatic logic [W-1:0] f_model(input logic [W-1:0] a, b, c, d);
        logic [W-1:0] s;
        s = a + b + (c - d);
        return s * d;
    endfunction

    always @(negedge clk) begin
        if (!rst && res_valid) begin
            exp_t e;
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result got id=%0d data=%0d exp none", res_id, res_data);
            end else begin
                e = sbq.pop_front();
                if ({res_id, res_data} !== e) begin
                    bad++;
                    $display("FAIL result got id=%0d data=%0d exp id=%0d data=%0d",
                             res_id, res_data, e.id, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int i);
        exp_t e;
        e.id   = IW'(i);
        e.data = f_model(opa[i], opb[i], opc[i], opd[i]);
        sbq.push_back(e);
    endtask

    task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
        opa[i] = W'(a);
        opb[i] = W'(b);
        opc[i] = W'(c);
        opd[i] = W'(d);
    endtask

    // Entered just after a posedge; returns just after the next posedge.
    task automatic step(input logic [N-1:0] valid, input logic [N-1:0] exp_ready);
        req_valid = valid;
        @(negedge clk);
        total++;
        if (req_ready !== exp_ready) begin
            bad++;
            $display("FAIL grant got=%b exp=%b", req_ready, exp_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30; i++) begin
            if (sbq.size() == 0 && !busy && !res_valid) break;
            @(posedge clk); #1;
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d exp 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({res_valid, res_id, res_data, pipe_a, pipe_b, pipe_c, pipe_d} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b id=%0d d=%0d a=%0d b=%0d c=%0d dd=%0d exp all 0",
                     res_valid, res_id, res_data, pipe_a, pipe_b, pipe_c, pipe_d);
        end
        total++;
        if ({idle, busy, req_ready} !== {1'b1, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL reset_status got idle=%b busy=%b ready=%b exp idle=1 busy=0 ready=0000",
                     idle, busy, req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        en = 1'b1;
        @(posedge clk); #1;
        set_ops(0, 1, 2, 5, 3);
        sbq.push_back('{id: 2'd0, data: 10'd15});
        step(4'b0001, 4'b0001);
        req_valid = '0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (res_valid !== (k == 4)) begin
                bad++;
                $display("FAIL latency edge=%0d got res_valid=%b exp %b", k, res_valid, (k == 4));
            end
            @(posedge clk); #1;
        end
        wait_drain();
    endtask

    task automatic test_wrap();
        set_ops(0, 600, 600, 10, 2);
        sbq.push_back('{id: 2'd0, data: 10'd368});
        step(4'b0001, 4'b0001);
        step(4'b0000, 4'b0000);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++)
                set_ops(i, $urandom_range(0, 1023), $urandom_range(0, 1023),
                        $urandom_range(0, 1023), $urandom_range(0, 1023));
            push_exp(c % N);
            step(4'b1111, 4'(1 << (c % N)));
        end
        req_valid = '0;
        wait_drain();
    endtask

    task automatic test_drain();
        for (int c = 0; c < 3; c++) begin
            set_ops(c, 100 + c, 7 * c, 50, c + 1);
            push_exp(c);
            step(4'b1111, 4'(1 << c));
        end
        en = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL drain_grant cyc=%0d got=%b exp=0000", k, req_ready);
            end
            if (k == 1) begin
                total++;
                if ({idle, busy} !== 2'b01) begin
                    bad++;
                    $display("FAIL drain_state got idle=%b busy=%b exp idle=0 busy=1", idle, busy);
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if ({idle, busy} !== 2'b10 || sbq.size() != 0) begin
            bad++;
            $display("FAIL drain_end got idle=%b busy=%b pending=%0d exp idle=1 busy=0 pending=0",
                     idle, busy, sbq.size());
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        @(posedge clk); #1;
        set_ops(0, 11, 22, 33, 4);
        set_ops(1, 5, 6, 7, 8);
        step(4'b0001, 4'b0001);
        step(4'b0010, 4'b0010);
        do_reset();
        @(negedge clk);
        total++;
        if ({res_valid, res_id, res_data, pipe_a, pipe_b, pipe_c, pipe_d, busy, idle} !== {{(1+IW+5*W+1){1'b0}}, 1'b1}) begin
            bad++;
            $display("FAIL midreset_outputs got v=%b id=%0d d=%0d a=%0d busy=%b idle=%b exp zeros idle=1",
                     res_valid, res_id, res_data, pipe_a, busy, idle);
        end
        @(posedge clk); #1;
        repeat (8) begin
            @(posedge clk); #1;
        end
        en = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_ops(i, 3 * i + 1, 9, 40, i + 2);
        push_exp(0);
        step(4'b1111, 4'b0001);
        step(4'b0000, 4'b0000);
        wait_drain();
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_seq [5] = '{4'b0100, 4'b0010, 4'b0100, 4'b0010, 4'b0100};
        logic [N-1:0] vld_seq [5] = '{4'b0100, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
        set_ops(1, 200, 300, 17, 5);
        set_ops(2, 1000, 900, 3, 9);
        for (int c = 0; c < 5; c++) begin
            push_exp(exp_seq[c] == 4'b0100 ? 2 : 1);
            step(vld_seq[c], exp_seq[c]);
        end
        step(4'b0000, 4'b0000);
        wait_drain();
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_ops(i, 0, 0, 0, 0);
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_drain();
        test_reset_mid();
        test_fairness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
